// File: rtl/safe_alu_pipe.sv
// safe_alu_pipe
// Two-stage valid/ready ALU pipeline. Stage 1 captures the operand beat, and
// stage 2 computes and holds the result and flags until the consumer takes it.
// It also keeps a sticky signed-overflow flag and a wrapping transfer counter.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (a, b, opcode, sat_mode)
//   out_valid/out_ready  result handshake (result, zero, carry, overflow, negative)
//   err_sticky           set by any output transfer that carries overflow=1
//   sticky_clr           synchronous clear of err_sticky (a set wins)
//   op_count             number of completed output transfers, wraps
module safe_alu_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  input  logic             sat_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative,
  output logic             err_sticky,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] op_count
);

  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  localparam logic [WIDTH-1:0] SIGNED_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SIGNED_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic             s1_sat;

  logic s2_load;
  logic s1_load;
  logic out_xfer;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] res_n;
  logic             zero_n;
  logic             carry_n;
  logic             ovf_n;
  logic             neg_n;

  // Stage 2 may take a new beat whenever its current one is absent or leaving.
  // Stage 1 may take a new beat when it is empty or its beat moves into stage 2,
  // so in_ready is combinational from out_ready.
  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;
  assign out_xfer = out_valid && out_ready;

  // One extra bit on both sides exposes the ADD carry-out and SUB/CMP borrow.
  assign sum_ext  = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff_ext = {1'b0, s1_a} - {1'b0, s1_b};

  // Stage 2 datapath. Overflow and carry always describe the unsaturated
  // arithmetic, while zero and negative describe what is actually delivered.
  // CMP is the exception: its result is forced to zero, and its flags come
  // from the subtraction.
  always_comb begin
    raw     = '0;
    carry_n = 1'b0;
    ovf_n   = 1'b0;
    res_n   = '0;
    zero_n  = 1'b0;
    neg_n   = 1'b0;
    case (s1_op)
      OP_ADD: begin
        raw     = sum_ext[MSB:0];
        carry_n = sum_ext[WIDTH];
        ovf_n   = (s1_a[MSB] == s1_b[MSB]) && (sum_ext[MSB] != s1_a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        raw     = diff_ext[MSB:0];
        carry_n = diff_ext[WIDTH];
        ovf_n   = (s1_a[MSB] != s1_b[MSB]) && (diff_ext[MSB] != s1_a[MSB]);
      end
      OP_AND: raw = s1_a & s1_b;
      OP_OR:  raw = s1_a | s1_b;
      OP_XOR: raw = s1_a ^ s1_b;
      OP_SHL: begin
        raw     = {s1_a[MSB-1:0], 1'b0};
        carry_n = s1_a[MSB];
      end
      OP_SHR: begin
        raw     = {1'b0, s1_a[MSB:1]};
        carry_n = s1_a[0];
      end
      default: raw = '0;
    endcase

    res_n = raw;
    if (s1_sat && ovf_n && (s1_op == OP_ADD || s1_op == OP_SUB)) begin
      res_n = s1_a[MSB] ? SIGNED_MIN : SIGNED_MAX;
    end
    zero_n = (res_n == '0);
    neg_n  = res_n[MSB];

    if (s1_op == OP_CMP) begin
      res_n  = '0;
      zero_n = (s1_a == s1_b);
      neg_n  = diff_ext[MSB];
    end
  end

  // Stage 1 register: captures the operand beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
      s1_sat   <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= a;
        s1_b   <= b;
        s1_op  <= opcode;
        s1_sat <= sat_mode;
      end
    end
  end

  // Stage 2 register. The payload only changes on a real load, so it stays
  // frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      negative  <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result   <= res_n;
        zero     <= zero_n;
        carry    <= carry_n;
        overflow <= ovf_n;
        negative <= neg_n;
      end
    end
  end

  // Transfer bookkeeping. A new overflow takes priority over a clear
  // in the same cycle, so that the error cannot be lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      op_count   <= '0;
    end else begin
      if (out_xfer && overflow) begin
        err_sticky <= 1'b1;
      end else if (sticky_clr) begin
        err_sticky <= 1'b0;
      end
      if (out_xfer) begin
        op_count <= op_count + 1'b1;
      end
    end
  end

endmodule

// File: doc/safe_alu_pipe.md
Name: safe_alu_pipe

Overview:
- Parametrised, pipelined successor to the 8-bit combinational safe ALU.
- Generalises the datapath to WIDTH bits and adds XOR, shift and compare ops, plus an optional signed-saturation mode.
- Two-stage valid/ready pipeline with backpressure, a sticky overflow error flag and a transfer counter.
- Sits between an operand-issuing controller and a result consumer on one clock domain.

Parameters:
- WIDTH, 8: operand/result width in bits (≥4).
- CNT_W, 16: width of op_count.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept operand beat
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- opcode  in  3  operation select
- sat_mode  in  1  1 = saturate signed ADD/SUB on overflow
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  operation result
- zero  out  1  result==0 (CMP: a==b)
- carry  out  1  ADD carry-out / SUB,CMP borrow / shifted-out bit; 0 for logic ops
- overflow  out  1  signed overflow (ADD/SUB/CMP only)
- negative  out  1  result MSB (CMP: MSB of a-b)
- err_sticky  out  1  set by any output transfer with overflow=1
- sticky_clr  in  1  synchronous clear of err_sticky
- op_count  out  CNT_W  number of completed output transfers, wraps

Behaviour:
- Reset (async, rst_n=0): all pipeline valids=0; result, flags, err_sticky, op_count=0; in_ready=1 once reset is released. Reset mid-operation discards all in-flight beats.
- Input transfer: in_valid&&in_ready at clk edge. Output transfer: out_valid&&out_ready.
- Stage 1 registers a, b, opcode, sat_mode. Stage 2 computes and registers result and flags.
- Latency: 2 cycles from input transfer to out_valid with no stall. Full throughput is 1 beat/cycle.
- Stage 2 loads when !out_valid||out_ready. Stage 1 loads when stage 1 is empty or advancing.
- in_ready = !s1_valid || (s2 load enable); this is combinational from out_ready.
- Output payload holds stable while out_valid && !out_ready.
- No beat is dropped or duplicated under any out_ready pattern.
- Opcodes:
  - 000 ADD: a+b
  - 001 SUB: a-b, carry=1 when a<b unsigned
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL1: result={a[W-2:0],0}, carry=a[W-1]
  - 110 SHR1 (logical): carry=a[0]
  - 111 CMP: flags of a-b, result=0
- Overflow:
  - ADD: a,b same sign and result sign differs.
  - SUB/CMP: a,b differ in sign and result sign differs from a.
- Saturation: sat_mode=1 and overflow on ADD/SUB clamps the result to signed max (0x7F..) if a was positive, else signed min (0x80..). overflow and carry still report the unsaturated values; zero and negative follow the saturated result.
- err_sticky: set on an output transfer with overflow=1. Cleared when sticky_clr=1. A set in the same cycle as a clear wins.
- op_count: increments by 1 per output transfer; 2^CNT_W-1 wraps to 0.

Test Plan:
- WIDTH=8, ADD 10+20 with out_ready=1 → out_valid exactly 2 cycles after accept; result=0x1E, zero=0, carry=0, overflow=0.
- ADD 127+1, sat_mode=0 → 0x80, overflow=1, negative=1, err_sticky=1. Same with sat_mode=1 → 0x7F, overflow=1, negative=0.
- SUB 20-50 → 0xE2, carry=1, negative=1. SUB 127-129 sat_mode=0 → 0xFE, overflow=1; sat_mode=1 → 0x7F. CMP 0x55,0x55 → result=0, zero=1. SHL1 0xAA → 0x54, carry=1.
- Backpressure: stream 5 ADDs (i+1 for i=0..4) back-to-back with out_ready low for 4 cycles → in_ready drops after 2 accepted beats. Results 1..5 delivered in order, none lost or duplicated. op_count=5.
- sticky_clr asserted in the same cycle as an overflowing output transfer → err_sticky stays 1. The next sticky_clr with no overflow → err_sticky=0.
- rst_n pulsed low for 3ns between edges while 2 beats are in flight → out_valid=0, op_count=0 immediately. After release, a new ADD 0+0 yields result=0, zero=1.
